// File: rtl/op_sequencer_pkg.sv
// Shared types for the LWE operation sequencer: opcodes, FSM state encoding and
// the latched operation descriptor.
package op_sequencer_pkg;

    localparam logic [1:0] OPCODE_ENCRYPT = 2'd0;
    localparam logic [1:0] OPCODE_DECRYPT = 2'd1;
    localparam logic [1:0] OPCODE_ADD     = 2'd2;
    localparam logic [1:0] OPCODE_MULT    = 2'd3;

    // Descriptor field widths; the top-level width parameters default to these.
    localparam int unsigned DescAddrWidth = 10;
    localparam int unsigned DescDimWidth  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StPassA,
        StPassB,
        StDrain,
        StDone
    } state_e;

    typedef struct packed {
        logic [1:0]               opcode;
        logic [DescDimWidth-1:0]  dim;
        logic [DescAddrWidth-1:0] op1_base;
        logic [DescAddrWidth-1:0] op2_base;
        logic [DescAddrWidth-1:0] out_base;
    } desc_t;

endpackage

// File: rtl/op_sequencer_if.sv
// Descriptor handshake and datapath issue bus of the operation sequencer.
// master = upstream/datapath side, slave = sequencer side.
interface op_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DIM_WIDTH  = 4
);

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [1:0]            cfg_opcode;
    logic [DIM_WIDTH-1:0]  cfg_dim;
    logic [ADDR_WIDTH-1:0] op1_base;
    logic [ADDR_WIDTH-1:0] op2_base;
    logic [ADDR_WIDTH-1:0] out_base;
    logic                  abort;
    logic                  dp_ready;
    logic                  issue_valid;
    logic [1:0]            opcode_out;
    logic [ADDR_WIDTH-1:0] op1_addr;
    logic [ADDR_WIDTH-1:0] op2_addr;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  op_select;
    logic [DIM_WIDTH-1:0]  row;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output cfg_valid, cfg_opcode, cfg_dim, op1_base, op2_base, out_base, abort, dp_ready,
        input  cfg_ready, issue_valid, opcode_out, op1_addr, op2_addr, out_addr, op_select,
               row, busy, done, err
    );

    modport slave (
        input  cfg_valid, cfg_opcode, cfg_dim, op1_base, op2_base, out_base, abort, dp_ready,
        output cfg_ready, issue_valid, opcode_out, op1_addr, op2_addr, out_addr, op_select,
               row, busy, done, err
    );

endinterface

// File: rtl/op_sequencer_seq_addr_gen.sv
// Combinational beat address generator: maps (opcode, pass, beat index) onto
// operand/result scratchpad addresses. All sums wrap modulo 2^ADDR_WIDTH.
module seq_addr_gen
    import op_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DIM_WIDTH  = 4,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic [1:0]            opcode_i,
    input  logic                  pass_b_i,
    input  logic [CNT_WIDTH-1:0]  idx_i,
    input  logic [DIM_WIDTH-1:0]  dim_i,
    input  logic [ADDR_WIDTH-1:0] op1_base_i,
    input  logic [ADDR_WIDTH-1:0] op2_base_i,
    input  logic [ADDR_WIDTH-1:0] out_base_i,
    output logic [ADDR_WIDTH-1:0] op1_addr_o,
    output logic [ADDR_WIDTH-1:0] op2_addr_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [DIM_WIDTH-1:0]  row_o,
    output logic                  op_select_o
);

    logic [ADDR_WIDTH-1:0] idx_a;
    logic [ADDR_WIDTH-1:0] dim_a;

    always_comb begin
        idx_a       = ADDR_WIDTH'(idx_i);
        dim_a       = ADDR_WIDTH'(dim_i);
        row_o       = DIM_WIDTH'(idx_i);
        op_select_o = pass_b_i;
        if (pass_b_i) begin
            // Second MULT pass: op1 pinned to its constant row, results follow pass A's.
            op1_addr_o = op1_base_i + dim_a;
            op2_addr_o = op2_base_i + idx_a;
            out_addr_o = out_base_i + dim_a + idx_a + ADDR_WIDTH'(1);
        end else begin
            op1_addr_o = op1_base_i + idx_a;
            op2_addr_o = (opcode_i == OPCODE_MULT) ? op2_base_i : op2_base_i + idx_a;
            out_addr_o = out_base_i + idx_a;
        end
    end

endmodule

// File: rtl/op_sequencer.sv
// Operation sequencer: accepts one descriptor, streams per-row beats with
// back-pressure, drains the datapath pipeline and pulses done. Outputs registered.
module op_sequencer
    import op_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DescAddrWidth,
    parameter int unsigned DIM_WIDTH  = DescDimWidth,
    parameter int unsigned MAX_DIM    = 10,
    parameter int unsigned PIPE_LAT   = 3,
    parameter int unsigned CNT_WIDTH  = DIM_WIDTH + 1
) (
    input logic           clk,
    input logic           rst_n,
    op_sequencer_if.slave bus
);

    localparam int unsigned DrainWidth = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   idx_q, idx_d;
    logic [DrainWidth-1:0]  drain_q, drain_d;
    desc_t                  desc_q, desc_d;

    logic                   cfg_ready_q, cfg_ready_d;
    logic                   issue_valid_q, issue_valid_d;
    logic [1:0]             opcode_out_q, opcode_out_d;
    logic [ADDR_WIDTH-1:0]  op1_addr_q, op1_addr_d;
    logic [ADDR_WIDTH-1:0]  op2_addr_q, op2_addr_d;
    logic [ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
    logic                   op_select_q, op_select_d;
    logic [DIM_WIDTH-1:0]   row_q, row_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   beat_ok;
    logic                   last_beat;
    logic                   dim_bad;

    logic [ADDR_WIDTH-1:0]  gen_op1, gen_op2, gen_out;
    logic [DIM_WIDTH-1:0]   gen_row;
    logic                   gen_sel;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        desc_d    = desc_q;
        err_d     = 1'b0;
        beat_ok   = issue_valid_q & bus.dp_ready;
        last_beat = (idx_q == CNT_WIDTH'(desc_q.dim));
        dim_bad   = (bus.cfg_dim == '0) || (32'(bus.cfg_dim) > MAX_DIM);

        unique case (state_q)
            StIdle: begin
                if (bus.cfg_valid) begin
                    if (dim_bad) begin
                        err_d = 1'b1;
                    end else begin
                        desc_d.opcode   = bus.cfg_opcode;
                        desc_d.dim      = bus.cfg_dim;
                        desc_d.op1_base = bus.op1_base;
                        desc_d.op2_base = bus.op2_base;
                        desc_d.out_base = bus.out_base;
                        idx_d           = '0;
                        state_d         = StPassA;
                    end
                end
            end
            StPassA, StPassB: begin
                if (beat_ok) begin
                    if (!last_beat) begin
                        idx_d = idx_q + CNT_WIDTH'(1);
                    end else if (state_q == StPassA && desc_q.opcode == OPCODE_MULT) begin
                        state_d = StPassB;
                        idx_d   = '0;
                    end else if (PIPE_LAT == 0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StDrain;
                        drain_d = '0;
                    end
                end
            end
            StDrain: begin
                if (drain_q == DrainWidth'(PIPE_LAT - 1)) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + DrainWidth'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (bus.abort && state_q != StIdle) begin
            state_d = StIdle;
        end
    end

    // Fed with next-state values so the registered outputs line up with the state.
    seq_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_addr_gen (
        .opcode_i    (desc_d.opcode),
        .pass_b_i    (state_d == StPassB),
        .idx_i       (idx_d),
        .dim_i       (desc_d.dim),
        .op1_base_i  (desc_d.op1_base),
        .op2_base_i  (desc_d.op2_base),
        .out_base_i  (desc_d.out_base),
        .op1_addr_o  (gen_op1),
        .op2_addr_o  (gen_op2),
        .out_addr_o  (gen_out),
        .row_o       (gen_row),
        .op_select_o (gen_sel)
    );

    always_comb begin
        issue_valid_d = (state_d == StPassA) || (state_d == StPassB);
        cfg_ready_d   = (state_d == StIdle);
        busy_d        = (state_d != StIdle);
        done_d        = (state_d == StDone);
        opcode_out_d  = busy_d ? desc_d.opcode : 2'b00;
        op1_addr_d    = issue_valid_d ? gen_op1 : '0;
        op2_addr_d    = issue_valid_d ? gen_op2 : '0;
        out_addr_d    = issue_valid_d ? gen_out : '0;
        row_d         = issue_valid_d ? gen_row : '0;
        op_select_d   = issue_valid_d & gen_sel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            drain_q       <= '0;
            desc_q        <= '0;
            cfg_ready_q   <= 1'b1;
            issue_valid_q <= 1'b0;
            opcode_out_q  <= '0;
            op1_addr_q    <= '0;
            op2_addr_q    <= '0;
            out_addr_q    <= '0;
            op_select_q   <= 1'b0;
            row_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            drain_q       <= drain_d;
            desc_q        <= desc_d;
            cfg_ready_q   <= cfg_ready_d;
            issue_valid_q <= issue_valid_d;
            opcode_out_q  <= opcode_out_d;
            op1_addr_q    <= op1_addr_d;
            op2_addr_q    <= op2_addr_d;
            out_addr_q    <= out_addr_d;
            op_select_q   <= op_select_d;
            row_q         <= row_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign bus.cfg_ready   = cfg_ready_q;
    assign bus.issue_valid = issue_valid_q;
    assign bus.opcode_out  = opcode_out_q;
    assign bus.op1_addr    = op1_addr_q;
    assign bus.op2_addr    = op2_addr_q;
    assign bus.out_addr    = out_addr_q;
    assign bus.op_select   = op_select_q;
    assign bus.row         = row_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer (ADDR_WIDTH=10, DIM_WIDTH=4, MAX_DIM=10, PIPE_LAT=3).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_op_sequencer;
    import op_sequencer_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    op_sequencer_if #(.ADDR_WIDTH(10), .DIM_WIDTH(4)) bus ();

    op_sequencer #(
        .ADDR_WIDTH (10),
        .DIM_WIDTH  (4),
        .MAX_DIM    (10),
        .PIPE_LAT   (3),
        .CNT_WIDTH  (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one descriptor for a single cycle; returns at the first beat's sample point.
    task automatic start_op(input logic [1:0] op, input logic [3:0] dim,
                            input logic [9:0] b1, input logic [9:0] b2, input logic [9:0] b3);
        bus.cfg_opcode = op;
        bus.cfg_dim    = dim;
        bus.op1_base   = b1;
        bus.op2_base   = b2;
        bus.out_base   = b3;
        bus.cfg_valid  = 1'b1;
        @(negedge clk);
        bus.cfg_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cfg_ready got %0b want 1", bus.cfg_ready);
        end
        checks++;
        if ({bus.issue_valid, bus.busy, bus.done, bus.err, bus.op_select} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %05b want 00000",
                     {bus.issue_valid, bus.busy, bus.done, bus.err, bus.op_select});
        end
        checks++;
        if ({bus.op1_addr, bus.op2_addr, bus.out_addr, bus.row, bus.opcode_out} !== 36'h0) begin
            errors++; $display("FAIL reset_addrs got %0h want 0",
                               {bus.op1_addr, bus.op2_addr, bus.out_addr, bus.row, bus.opcode_out});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int beats, last_c, done_c;
        logic [9:0] e;
        beats = 0; last_c = -1; done_c = -1;
        start_op(OPCODE_ADD, 4'd3, 10'h010, 10'h020, 10'h030);
        checks++;
        if (bus.busy !== 1'b1 || bus.cfg_ready !== 1'b0) begin
            errors++; $display("FAIL add_busy got busy=%0b ready=%0b want 1/0", bus.busy, bus.cfg_ready);
        end
        checks++;
        if (bus.opcode_out !== OPCODE_ADD) begin
            errors++; $display("FAIL add_opcode got %0d want %0d", bus.opcode_out, OPCODE_ADD);
        end
        for (int c = 1; c <= 30; c++) begin
            if (bus.done) begin done_c = c; break; end
            if (bus.issue_valid) begin
                e = 10'h010 + 10'(beats);
                checks++;
                if (bus.op1_addr !== e || bus.op2_addr !== e + 10'h010 || bus.out_addr !== e + 10'h020
                    || bus.row !== 4'(beats) || bus.op_select !== 1'b0) begin
                    errors++;
                    $display("FAIL add_beat%0d got op1=%0h op2=%0h out=%0h row=%0d sel=%0b want %0h/%0h/%0h/%0d/0",
                             beats, bus.op1_addr, bus.op2_addr, bus.out_addr, bus.row, bus.op_select,
                             e, e + 10'h010, e + 10'h020, beats);
                end
                beats++; last_c = c;
            end
            @(negedge clk);
        end
        checks++;
        if (beats !== 4) begin errors++; $display("FAIL add_beats got %0d want 4", beats); end
        checks++;
        if (done_c < 0 || done_c - last_c !== 4) begin
            errors++; $display("FAIL add_done_delay got %0d want 4", done_c - last_c);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL add_after_done got done=%0b ready=%0b busy=%0b want 0/1/0",
                               bus.done, bus.cfg_ready, bus.busy);
        end
    endtask

    task automatic test_mult();
        int e_op1 [6] = '{0, 1, 2, 2, 2, 2};
        int e_op2 [6] = '{8, 8, 8, 8, 9, 10};
        int e_row [6] = '{0, 1, 2, 0, 1, 2};
        int e_sel [6] = '{0, 0, 0, 1, 1, 1};
        int beats, last_c, done_c;
        beats = 0; last_c = -1; done_c = -1;
        start_op(OPCODE_MULT, 4'd2, 10'd0, 10'd8, 10'd16);
        for (int c = 1; c <= 30; c++) begin
            if (bus.done) begin done_c = c; break; end
            if (bus.issue_valid && beats < 6) begin
                checks++;
                if (bus.op1_addr !== 10'(e_op1[beats]) || bus.op2_addr !== 10'(e_op2[beats])
                    || bus.out_addr !== 10'(16 + beats) || bus.row !== 4'(e_row[beats])
                    || bus.op_select !== 1'(e_sel[beats])) begin
                    errors++;
                    $display("FAIL mult_beat%0d got op1=%0d op2=%0d out=%0d row=%0d sel=%0b want %0d/%0d/%0d/%0d/%0d",
                             beats, bus.op1_addr, bus.op2_addr, bus.out_addr, bus.row, bus.op_select,
                             e_op1[beats], e_op2[beats], 16 + beats, e_row[beats], e_sel[beats]);
                end
                beats++; last_c = c;
            end else if (bus.issue_valid) begin
                beats++;
            end
            @(negedge clk);
        end
        checks++;
        if (beats !== 6) begin errors++; $display("FAIL mult_beats got %0d want 6", beats); end
        checks++;
        if (done_c < 0 || done_c - last_c !== 4) begin
            errors++; $display("FAIL mult_done_delay got %0d want 4", done_c - last_c);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int beats, first_c, done_c, stall;
        beats = 0; first_c = -1; done_c = -1; stall = 3;
        start_op(OPCODE_ENCRYPT, 4'd4, 10'h100, 10'h200, 10'h300);
        for (int c = 1; c <= 40; c++) begin
            if (bus.done) begin done_c = c; break; end
            if (bus.issue_valid) begin
                if (first_c < 0) first_c = c;
                if (bus.row == 4'd2 && stall > 0) begin
                    bus.dp_ready = 1'b0;
                    stall--;
                    checks++;
                    if (bus.op1_addr !== 10'h102 || bus.out_addr !== 10'h302) begin
                        errors++; $display("FAIL stall_frozen got op1=%0h out=%0h want 102/302",
                                           bus.op1_addr, bus.out_addr);
                    end
                end else begin
                    bus.dp_ready = 1'b1;
                    checks++;
                    if (bus.op1_addr !== 10'h100 + 10'(beats) || bus.row !== 4'(beats)) begin
                        errors++; $display("FAIL stall_beat%0d got op1=%0h row=%0d want %0h/%0d",
                                           beats, bus.op1_addr, bus.row, 10'h100 + 10'(beats), beats);
                    end
                    beats++;
                end
            end else begin
                bus.dp_ready = 1'b1;
            end
            @(negedge clk);
        end
        bus.dp_ready = 1'b1;
        checks++;
        if (beats !== 5) begin errors++; $display("FAIL stall_beats got %0d want 5", beats); end
        checks++;
        if (done_c < 0 || done_c - first_c !== 11) begin
            errors++; $display("FAIL stall_done_delay got %0d want 11", done_c - first_c);
        end
        @(negedge clk);
    endtask

    task automatic test_bad_dim();
        logic seen;
        logic [3:0] dims [2] = '{4'd0, 4'd11};
        for (int k = 0; k < 2; k++) begin
            start_op(OPCODE_ADD, dims[k], 10'h001, 10'h002, 10'h003);
            checks++;
            if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1
                || bus.issue_valid !== 1'b0) begin
                errors++; $display("FAIL bad_dim%0d got err=%0b busy=%0b ready=%0b iv=%0b want 1/0/1/0",
                                   dims[k], bus.err, bus.busy, bus.cfg_ready, bus.issue_valid);
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen |= bus.err | bus.busy | bus.issue_valid | bus.done;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL bad_dim_quiet got activity=1 want 0"); end
    endtask

    task automatic test_abort();
        logic hit, seen;
        int beats, done_c;
        hit = 1'b0; seen = 1'b0;
        bus.abort = 1'b1;
        start_op(OPCODE_MULT, 4'd3, 10'h100, 10'h140, 10'h180);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.issue_valid !== 1'b1) begin
            errors++; $display("FAIL abort_idle_accept got busy=%0b iv=%0b want 1/1", bus.busy, bus.issue_valid);
        end
        for (int c = 0; c < 20; c++) begin
            seen |= bus.done;
            if (bus.issue_valid && bus.op_select && bus.row == 4'd1) begin
                hit = 1'b1;
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (hit !== 1'b1 || bus.issue_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL abort_to_idle got hit=%0b iv=%0b busy=%0b ready=%0b want 1/0/0/1",
                               hit, bus.issue_valid, bus.busy, bus.cfg_ready);
        end
        for (int c = 0; c < 8; c++) begin
            seen |= bus.done | bus.issue_valid;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got activity=1 want 0"); end
        beats = 0; done_c = -1;
        start_op(OPCODE_ADD, 4'd1, 10'h005, 10'h006, 10'h007);
        for (int c = 1; c <= 20; c++) begin
            if (bus.done) begin done_c = c; break; end
            if (bus.issue_valid) beats++;
            @(negedge clk);
        end
        checks++;
        if (beats !== 2 || done_c !== 6) begin
            errors++; $display("FAIL abort_new_add got beats=%0d done_at=%0d want 2/6", beats, done_c);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_wrap();
        int beats;
        logic [9:0] e;
        beats = 0;
        start_op(OPCODE_ADD, 4'd3, 10'h040, 10'h050, 10'h060);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.issue_valid, bus.busy, bus.done, bus.op_select} !== 4'b0 || bus.cfg_ready !== 1'b1
            || {bus.op1_addr, bus.op2_addr, bus.out_addr, bus.row, bus.opcode_out} !== 36'h0) begin
            errors++; $display("FAIL midreset_clear got iv=%0b busy=%0b ready=%0b op1=%0h row=%0d want 0/0/1/0/0",
                               bus.issue_valid, bus.busy, bus.cfg_ready, bus.op1_addr, bus.row);
        end
        rst_n = 1'b1;
        start_op(OPCODE_ENCRYPT, 4'd3, 10'h3FE, 10'h3FD, 10'h000);
        for (int c = 1; c <= 20; c++) begin
            if (bus.done) break;
            if (bus.issue_valid) begin
                e = 10'h3FE + 10'(beats);
                checks++;
                if (bus.op1_addr !== e || bus.op2_addr !== e - 10'h001) begin
                    errors++; $display("FAIL wrap_beat%0d got op1=%0h op2=%0h want %0h/%0h",
                                       beats, bus.op1_addr, bus.op2_addr, e, e - 10'h001);
                end
                beats++;
            end
            @(negedge clk);
        end
        checks++;
        if (beats !== 4) begin errors++; $display("FAIL wrap_beats got %0d want 4", beats); end
        @(negedge clk);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_opcode = 2'd0;
        bus.cfg_dim    = 4'd0;
        bus.op1_base   = 10'd0;
        bus.op2_base   = 10'd0;
        bus.out_base   = 10'd0;
        bus.abort      = 1'b0;
        bus.dp_ready   = 1'b1;
        @(negedge clk);
        test_reset();
        test_add();
        test_mult();
        test_stall();
        test_bad_dim();
        test_abort();
        test_reset_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/op_sequencer.md
Name: op_sequencer

Overview:
Parametrised address/row sequencer for the LWE encrypt/decrypt/add/mult datapath.
- Accepts one operation descriptor through a valid/ready handshake.
- Streams per-row operand and result addresses to the datapath with back-pressure.
- Waits for the datapath pipeline to drain, then pulses done.
- Adds over the previous sequencer: runtime dimension, datapath stall, abort, descriptor error check and pipeline-latency drain.

Parameters:
ADDR_WIDTH, 10, scratchpad address width
DIM_WIDTH, 4, width of dimension and row fields
MAX_DIM, 10, largest legal runtime dimension
PIPE_LAT, 3, datapath latency in cycles from accepted beat to result written (≥0)
CNT_WIDTH, DIM_WIDTH+1, width of the internal beat counter (must hold 2*MAX_DIM+1)

Ports:
clk  in  1  clock
rst_n  in  1  reset
cfg_valid  in  1  descriptor valid
cfg_ready  out  1  sequencer idle, descriptor accepted when cfg_valid&cfg_ready
cfg_opcode  in  2  ENCRYPT/DECRYPT/ADD/MULT
cfg_dim  in  DIM_WIDTH  runtime dimension n
op1_base  in  ADDR_WIDTH  operand 1 base address
op2_base  in  ADDR_WIDTH  operand 2 base address
out_base  in  ADDR_WIDTH  result base address
abort  in  1  cancel the current operation
dp_ready  in  1  datapath accepts the current beat
issue_valid  out  1  beat on outputs is valid
opcode_out  out  2  latched opcode
op1_addr  out  ADDR_WIDTH  operand 1 address
op2_addr  out  ADDR_WIDTH  operand 2 address
out_addr  out  ADDR_WIDTH  result address
op_select  out  1  MULT phase: 0 = op1 pass, 1 = op2 pass
row  out  DIM_WIDTH  row index of the current beat
busy  out  1  state ≠ IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle illegal-descriptor pulse

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk. Reset has priority over everything, including mid-operation. All outputs are 0 except cfg_ready=1. State goes to IDLE and all latched descriptor fields are cleared.
- States: IDLE, PASS_A, PASS_B, DRAIN, DONE. All outputs are registered.
- IDLE:
  - cfg_ready=1.
  - On accept with cfg_dim==0 or cfg_dim>MAX_DIM: err=1 for one cycle; stay in IDLE; nothing is latched.
  - On a legal accept: latch the descriptor, set beat index i=0, go to PASS_A.
- Beats per pass: dim+1 (rows 0..dim, covering the constant row).
- A beat advances only on a cycle where issue_valid&dp_ready. While dp_ready=0, all outputs and counters hold.
- PASS_A, issue_valid=1, row=i, by opcode:
  - ENCRYPT/DECRYPT/ADD: op1=op1_base+i, op2=op2_base+i, out=out_base+i, op_select=0.
  - MULT: op1=op1_base+i, op2=op2_base, out=out_base+i, op_select=0.
- Exit from PASS_A, when the beat with i==dim is accepted:
  - MULT: go to PASS_B with i=0.
  - Other opcodes: go to DRAIN.
- PASS_B (MULT only):
  - op2=op2_base+i, op1=op1_base+dim, out=out_base+dim+1+i, op_select=1, row=i.
  - Last accepted beat goes to DRAIN.
- DRAIN: issue_valid=0; count PIPE_LAT cycles, ignoring dp_ready. If PIPE_LAT==0, go directly to DONE.
- DONE: done=1 for exactly one cycle; next state IDLE, so cfg_ready=1 on the following cycle.
- Abort: in any non-IDLE state, the next state is IDLE with issue_valid=0 and no done pulse. Abort in IDLE is ignored. Abort and cfg_valid in the same IDLE cycle: the descriptor is accepted.
- busy=1 from the cycle after accept through the DONE cycle inclusive.
- Address arithmetic wraps modulo 2^ADDR_WIDTH, with no error.
- Row and beat counters never exceed MAX_DIM and 2*MAX_DIM+1 respectively.
- cfg_valid while busy is not accepted (cfg_ready=0); the upstream must hold it.

Decomposition:
- Shared package holds:
  - opcode constants OPCODE_ENCRYPT=0, OPCODE_DECRYPT=1, OPCODE_ADD=2, OPCODE_MULT=3;
  - the state encoding;
  - the descriptor struct type.
- One sub-module: seq_addr_gen. It is purely combinational; from opcode, phase, index i, dim and the bases it produces op1/op2/out addresses and row. The FSM in op_sequencer registers those outputs.

Test Plan:
- ADD, dim=3, bases 0x010/0x020/0x030, dp_ready=1, PIPE_LAT=3 -> 4 beats with op1 0x010..0x013, op2 0x020..0x023, out 0x030..0x033; done 1 cycle, 4 cycles after the last beat; cfg_ready=1 the next cycle.
- MULT, dim=2, bases 0/8/16 -> 6 beats. op_select=0,0,0,1,1,1. row=0,1,2,0,1,2. out=16..21. op2=8,9,10 in PASS_B.
- ENCRYPT, dim=4 with dp_ready low on beat 2 for 3 cycles -> outputs frozen at op1=base+2 for 3 cycles; total beats still 5; done timing shifts by exactly 3 cycles.
- cfg_dim=0, then cfg_dim=MAX_DIM+1 -> err pulse each time; busy stays 0; no issue_valid; no done.
- Abort asserted during PASS_B beat 1 of MULT dim=3 -> next cycle IDLE, issue_valid=0, done never asserted. A new ADD is then accepted normally.
- rst_n low mid-PASS_A, and op1_base=0x3FE with dim=3 after reset -> all outputs cleared. Wrap case: op1 = 0x3FE, 0x3FF, 0x000, 0x001.
